// File: rtl/hilo_mdu_ctrl.sv
// rtl/hilo_mdu_ctrl.sv - HI/LO owner with 1-cycle multiply and 32-step restoring divider
module hilo_mdu_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid_EXE,
  input  logic [2:0]        op_code_EXE,
  input  logic [DATA_W-1:0] op_a_EXE,
  input  logic [DATA_W-1:0] op_b_EXE,
  input  logic [1:0]        MFHL_ID_EXE,
  input  logic              flush,
  output logic              op_ready,
  output logic              stall_EXE,
  output logic              busy,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  // a_q holds the multiplicand, or the dividend that shifts into the quotient
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                msign_q, msign_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                dz_q, dz_d;

  logic                legal;
  logic                accept;
  logic                busy_c;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0]     div_tmp;
  logic [DATA_W:0]     div_diff;
  logic                a_neg;
  logic                b_neg;
  logic                div_signed;

  assign legal  = (op_code_EXE != 3'd0) && (op_code_EXE != 3'd7);
  assign accept = op_valid_EXE & legal & (state_q == S_IDLE) & ~flush;
  assign busy_c = (state_q != S_IDLE);

  assign op_ready  = accept;
  assign busy      = busy_c;
  assign stall_EXE = busy_c & ((|MFHL_ID_EXE) | (op_valid_EXE & legal));
  assign HI        = hi_q;
  assign LO        = lo_q;

  // Next-state, datapath step and result write-back
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    msign_d  = msign_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;

    // Sign-extending to full width makes one multiplier serve both MULT and MULTU
    prod = {{DATA_W{msign_q & a_q[DATA_W-1]}}, a_q} *
           {{DATA_W{msign_q & b_q[DATA_W-1]}}, b_q};

    // Borrow out of the top bit means the trial subtraction failed
    div_tmp  = {rem_q, a_q[DATA_W-1]};
    div_diff = div_tmp - {1'b0, b_q};

    div_signed = (op_code_EXE == 3'd3);
    a_neg      = div_signed & op_a_EXE[DATA_W-1];
    b_neg      = div_signed & op_b_EXE[DATA_W-1];

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_code_EXE)
            3'd1, 3'd2: begin
              a_d     = op_a_EXE;
              b_d     = op_b_EXE;
              msign_d = (op_code_EXE == 3'd1);
              state_d = S_MUL;
            end
            3'd3, 3'd4: begin
              a_d     = a_neg ? -op_a_EXE : op_a_EXE;
              b_d     = b_neg ? -op_b_EXE : op_b_EXE;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              dz_d    = (op_b_EXE == '0);
              rem_d   = '0;
              cnt_d   = '0;
              state_d = S_DIV;
            end
            3'd5:    hi_d = op_a_EXE;
            3'd6:    lo_d = op_a_EXE;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (!flush) begin
          {hi_d, lo_d} = prod;
        end
        state_d = S_IDLE;
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (!div_diff[DATA_W]) begin
            rem_d = div_diff[DATA_W-1:0];
            a_d   = {a_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = div_tmp[DATA_W-1:0];
            a_d   = {a_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        // Divide-by-zero leaves |a| as remainder, so only the quotient needs forcing
        if (!flush) begin
          lo_d = dz_q ? '1 : (qneg_q ? -a_q : a_q);
          hi_d = rneg_q ? -rem_q : rem_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      msign_q <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      msign_q <= msign_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb/tb_hilo_mdu_ctrl.sv - scoreboard bench for hilo_mdu_ctrl
module tb_hilo_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_EXE;
  logic [2:0]  op_code_EXE;
  logic [31:0] op_a_EXE;
  logic [31:0] op_b_EXE;
  logic [1:0]  MFHL_ID_EXE;
  logic        flush;
  logic        op_ready;
  logic        stall_EXE;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_mdu_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .op_valid_EXE(op_valid_EXE), .op_code_EXE(op_code_EXE),
    .op_a_EXE(op_a_EXE), .op_b_EXE(op_b_EXE), .MFHL_ID_EXE(MFHL_ID_EXE), .flush(flush),
    .op_ready(op_ready), .stall_EXE(stall_EXE), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result {HI,LO} of an op, straight from the arithmetic rules
  function automatic logic [63:0] ref_op(input logic [2:0] code, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (code)
      3'd1: return sa * sb;
      3'd2: return {32'b0, a} * {32'b0, b};
      3'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      3'd5: return {a, lo};
      3'd6: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  function automatic int latency(input logic [2:0] code);
    if (code == 3'd1 || code == 3'd2) return 1;
    if (code == 3'd3 || code == 3'd4) return 33;
    return 0;
  endfunction

  // Monitor: HI/LO are compared whenever a result becomes visible
  initial begin
    logic pb;
    logic pm;
    logic [63:0] e;
    pb = 1'b0;
    pm = 1'b0;
    forever begin
      @(negedge clk);
      if (pm || (pb && !busy)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL monitor: HI/LO update with no expectation queued (HI=%h LO=%h)", HI, LO);
        end else begin
          e = exp_q.pop_front();
          chk("hi_result", HI, e[63:32]);
          chk("lo_result", LO, e[31:0]);
        end
      end
      pm = op_ready && (op_code_EXE == 3'd5 || op_code_EXE == 3'd6);
      pb = busy;
    end
  end

  // Issue one op from IDLE, optionally flushing in busy cycle flush_cyc
  task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int flush_cyc, input logic [1:0] mfhl);
    int lat;
    logic [63:0] r;
    lat = latency(code);
    @(posedge clk); #1;
    op_valid_EXE = 1'b1; op_code_EXE = code; op_a_EXE = a; op_b_EXE = b; MFHL_ID_EXE = 2'b00;
    #1;
    chk("op_ready", {31'b0, op_ready}, 32'd1);
    chk("stall_idle", {31'b0, stall_EXE}, 32'd0);
    r = ref_op(code, a, b, m_hi, m_lo);
    if (flush_cyc > 0 && flush_cyc <= lat) r = {m_hi, m_lo};
    {m_hi, m_lo} = r;
    exp_q.push_back(r);
    @(posedge clk); #1;
    op_valid_EXE = 1'b0;
    MFHL_ID_EXE = mfhl;
    for (int c = 1; c <= lat; c++) begin
      if (c == flush_cyc) flush = 1'b1;
      #1;
      chk("busy", {31'b0, busy}, 32'd1);
      chk("stall_busy", {31'b0, stall_EXE}, {31'b0, |mfhl});
      @(posedge clk); #1;
      flush = 1'b0;
      if (c == flush_cyc) break;
    end
    #1;
    chk("busy_done", {31'b0, busy}, 32'd0);
    chk("stall_release", {31'b0, stall_EXE}, 32'd0);
    MFHL_ID_EXE = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    rst = 1'b1; op_valid_EXE = 1'b0; op_code_EXE = 3'd0; op_a_EXE = '0; op_b_EXE = '0;
    MFHL_ID_EXE = 2'b00; flush = 1'b0;
    #1;
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_stall", {31'b0, stall_EXE}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed cases with hand-derived results
    run_op(3'd1, 32'hFFFFFFFB, 32'd3, 0, 2'b00);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFF1);
    run_op(3'd3, 32'd7, 32'hFFFFFFFE, 0, 2'b01);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'h00000001);
    run_op(3'd4, 32'h12345678, 32'd0, 0, 2'b10);
    chk("divz_hi", HI, 32'h12345678);
    chk("divz_lo", LO, 32'hFFFFFFFF);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 2'b00);
    chk("ovf_lo", LO, 32'h80000000);
    chk("ovf_hi", HI, 32'h0);

    // Back-to-back MTHI / MTLO
    @(posedge clk); #1;
    op_valid_EXE = 1'b1; op_code_EXE = 3'd5; op_a_EXE = 32'hDEADBEEF;
    #1;
    chk("mthi_ready", {31'b0, op_ready}, 32'd1);
    chk("mthi_stall", {31'b0, stall_EXE}, 32'd0);
    m_hi = 32'hDEADBEEF; exp_q.push_back({m_hi, m_lo});
    @(posedge clk); #1;
    op_code_EXE = 3'd6; op_a_EXE = 32'hCAFEF00D;
    #1;
    chk("mthi_visible", HI, 32'hDEADBEEF);
    chk("mtlo_ready", {31'b0, op_ready}, 32'd1);
    chk("mtlo_stall", {31'b0, stall_EXE}, 32'd0);
    m_lo = 32'hCAFEF00D; exp_q.push_back({m_hi, m_lo});
    @(posedge clk); #1;
    op_valid_EXE = 1'b0;
    #1;
    chk("mtlo_visible", LO, 32'hCAFEF00D);

    // MULTU held behind a divide
    @(posedge clk); #1;
    op_valid_EXE = 1'b1; op_code_EXE = 3'd4; op_a_EXE = 32'd1000; op_b_EXE = 32'd7;
    #1;
    chk("hold_div_ready", {31'b0, op_ready}, 32'd1);
    r = ref_op(3'd4, 32'd1000, 32'd7, m_hi, m_lo); {m_hi, m_lo} = r; exp_q.push_back(r);
    @(posedge clk); #1;
    op_code_EXE = 3'd2; op_a_EXE = 32'hABCDEF01; op_b_EXE = 32'h12345;
    for (int c = 1; c <= 33; c++) begin
      #1;
      chk("held_ready", {31'b0, op_ready}, 32'd0);
      chk("held_stall", {31'b0, stall_EXE}, 32'd1);
      @(posedge clk); #1;
    end
    #1;
    chk("held_accept", {31'b0, op_ready}, 32'd1);
    chk("held_nostall", {31'b0, stall_EXE}, 32'd0);
    r = ref_op(3'd2, 32'hABCDEF01, 32'h12345, m_hi, m_lo); {m_hi, m_lo} = r; exp_q.push_back(r);
    @(posedge clk); #1;
    op_valid_EXE = 1'b0;
    @(posedge clk); #1;
    chk("held_mul_done", {31'b0, busy}, 32'd0);

    // Flush mid-divide, then an immediate MULTU
    run_op(3'd3, 32'h55555555, 32'd3, 10, 2'b00);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 0, 2'b00);
    chk("post_flush_hi", HI, 32'h1);
    chk("post_flush_lo", LO, 32'hFFFFFFFE);

    // Illegal codes and flush-with-op in IDLE
    @(posedge clk); #1;
    op_valid_EXE = 1'b1; op_code_EXE = 3'd0;
    #1;
    chk("illegal0_ready", {31'b0, op_ready}, 32'd0);
    chk("illegal0_stall", {31'b0, stall_EXE}, 32'd0);
    op_code_EXE = 3'd7;
    #1;
    chk("illegal7_ready", {31'b0, op_ready}, 32'd0);
    op_code_EXE = 3'd5; op_a_EXE = 32'h11112222; flush = 1'b1;
    #1;
    chk("flush_op_ready", {31'b0, op_ready}, 32'd0);
    @(posedge clk); #1;
    op_valid_EXE = 1'b0; flush = 1'b0;
    #1;
    chk("flush_op_busy", {31'b0, busy}, 32'd0);
    chk("flush_op_hi", HI, m_hi);
    chk("flush_op_lo", LO, m_lo);

    // Randomised ops, with corner operands and occasional flushes
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  code;
      logic [31:0] a, b;
      int sel, fc;
      code = 3'($urandom_range(1, 6));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
      else if (sel == 3) a = -a >> 4;
      fc = 0;
      if ($urandom_range(0, 4) == 0 && latency(code) > 0) fc = $urandom_range(1, latency(code));
      run_op(code, a, b, fc, 2'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a divide
    @(posedge clk); #1;
    op_valid_EXE = 1'b1; op_code_EXE = 3'd3; op_a_EXE = 32'h7FFF0000; op_b_EXE = 32'd13;
    #1;
    chk("rstdiv_ready", {31'b0, op_ready}, 32'd1);
    m_hi = '0; m_lo = '0; exp_q.push_back(64'h0);
    @(posedge clk); #1;
    op_valid_EXE = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_hi", HI, 32'h0);
    chk("async_rst_lo", LO, 32'h0);
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    MFHL_ID_EXE = 2'b01;
    #1;
    chk("mflo_stall", {31'b0, stall_EXE}, 32'd0);
    chk("mflo_value", LO, 32'h0);
    MFHL_ID_EXE = 2'b00;

    repeat (4) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
